// File: rtl/div_unit.sv
// div_unit: RV32M iterative divider (DIV, DIVU, REM, REMU).
// Restoring radix-2 division on operand magnitudes, one quotient bit per
// cycle. Divide-by-zero and signed overflow skip the iteration and go
// straight to DONE. Result and address are registered and held until the
// next DONE; RegWrite_o is the only qualifier and is suppressed for x0.
module div_unit (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        reg_write;

  logic        rem_op_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [4:0]  rd_q;
  logic [4:0]  count_q;
  logic [31:0] divisor_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_data_q;

  // Decode of the request as presented on the inputs (used only at capture).
  logic        is_signed;
  logic        is_rem;
  logic        rs1_neg;
  logic        rs2_neg;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_result;

  assign is_signed = ~op_i[0];
  assign is_rem    = op_i[1];
  assign rs1_neg   = is_signed & rs1_i[31];
  assign rs2_neg   = is_signed & rs2_i[31];
  assign rs1_mag   = rs1_neg ? (~rs1_i + 32'd1) : rs1_i;
  assign rs2_mag   = rs2_neg ? (~rs2_i + 32'd1) : rs2_i;
  assign div_zero  = (rs2_i == 32'd0);
  assign overflow  = is_signed & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
  assign special   = div_zero | overflow;
  assign special_result = div_zero ? (is_rem ? rs1_i : 32'hFFFF_FFFF)
                                   : (is_rem ? 32'd0 : 32'h8000_0000);

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
  logic [31:0] result_final;

  assign shifted      = {rem_q, quo_q[31]};
  assign diff         = shifted - {1'b0, divisor_q};
  assign fits         = ~diff[32];
  assign rem_next     = fits ? diff[31:0] : shifted[31:0];
  assign quo_next     = {quo_q[30:0], fits};
  assign quo_final    = neg_quo_q ? (~quo_next + 32'd1) : quo_next;
  assign rem_final    = neg_rem_q ? (~rem_next + 32'd1) : rem_next;
  assign result_final = rem_op_q ? rem_final : quo_final;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and the write strobe, which kill can veto in DONE.
  always_comb begin
    state_d   = state_q;
    reg_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (count_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        reg_write = ~kill_i & (rd_q != 5'd0);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, iteration, and loading of the held result registers.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= 5'd0;
      count_q   <= 5'd0;
      divisor_q <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_op_q  <= is_rem;
            neg_quo_q <= rs1_neg ^ rs2_neg;
            neg_rem_q <= rs1_neg;
            rd_q      <= rd_addr_i;
            count_q   <= 5'd0;
            divisor_q <= rs2_mag;
            quo_q     <= rs1_mag;
            rem_q     <= 32'd0;
            if (special) begin
              rd_addr_q <= rd_addr_i;
              rd_data_q <= special_result;
            end
          end
        end
        CALC: begin
          if (!kill_i) begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) begin
              rd_addr_q <= rd_q;
              rd_data_q <= result_final;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign RegWrite_o = reg_write;
  assign RDaddr_o   = rd_addr_q;
  assign RDdata_o   = rd_data_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Each operation is observed one window per clock cycle (sampled just after
// the falling edge); busy cycles, the write window, and the held result are
// compared against hand-computed values.
module tb_div_unit;

  logic        clk_i     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start_i   = 1'b0;
  logic [1:0]  op_i      = 2'b00;
  logic [31:0] rs1_i     = 32'd0;
  logic [31:0] rs2_i     = 32'd0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        kill_i    = 1'b0;
  logic        busy_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit dut (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rd_addr_i  (rd_addr_i),
    .kill_i     (kill_i),
    .busy_o     (busy_o),
    .RegWrite_o (RegWrite_o),
    .RDaddr_o   (RDaddr_o),
    .RDdata_o   (RDdata_o)
  );

  // Free-running clock, 10 ns period.
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request and watches 40 cycle windows. pulseWin injects a
  // second start in that window, killWin raises kill in that window
  // (-2 = kill together with the start), expWin = -1 means no write.
  task automatic applyStimulus(input string name, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int expBusy,
                               input int expWin, input logic [31:0] expData,
                               input logic [4:0] expAddr, input int pulseWin,
                               input int killWin);
    int busyCnt  = 0;
    int writeCnt = 0;
    int writeWin = -1;
    @(negedge clk_i);
    op_i      = op;
    rs1_i     = a;
    rs2_i     = b;
    rd_addr_i = rd;
    start_i   = 1'b1;
    kill_i    = (killWin == -2);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    kill_i  = 1'b0;
    rs1_i   = 32'hDEAD_BEEF;
    rs2_i   = 32'h0000_0001;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk_i);
      start_i = (w == pulseWin);
      if (w == pulseWin) begin
        op_i      = OP_DIVU;
        rs1_i     = 32'd9;
        rs2_i     = 32'd1;
        rd_addr_i = 5'd12;
      end
      kill_i = (w == killWin);
      #1;
      if (busy_o) busyCnt++;
      if (RegWrite_o) begin
        writeCnt++;
        writeWin = w;
      end
    end
    start_i = 1'b0;
    kill_i  = 1'b0;
    checkOutput({name, " busy"}, 32'(busyCnt), 32'(expBusy));
    checkOutput({name, " wrcnt"}, 32'(writeCnt), (expWin >= 0) ? 32'd1 : 32'd0);
    checkOutput({name, " wrwin"}, 32'(writeWin), 32'(expWin));
    checkOutput({name, " data"}, RDdata_o, expData);
    checkOutput({name, " addr"}, {27'd0, RDaddr_o}, {27'd0, expAddr});
  endtask

  // Asynchronous reset in the middle of an iteration, checked without a clock.
  task automatic resetMidCalc();
    @(negedge clk_i);
    op_i      = OP_DIVU;
    rs1_i     = 32'hFFFF_FFFF;
    rs2_i     = 32'd3;
    rd_addr_i = 5'd13;
    start_i   = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int w = 0; w < 20; w++) @(negedge clk_i);
    #1;
    checkOutput("rstmid busy before", {31'd0, busy_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rstmid wr", {31'd0, RegWrite_o}, 32'd0);
    checkOutput("rstmid addr", {27'd0, RDaddr_o}, 32'd0);
    checkOutput("rstmid data", RDdata_o, 32'd0);
    @(negedge clk_i);
    reset_n = 1'b1;
  endtask

  // Directed test sequence.
  initial begin
    #2;
    checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset wr", {31'd0, RegWrite_o}, 32'd0);
    checkOutput("reset addr", {27'd0, RDaddr_o}, 32'd0);
    checkOutput("reset data", RDdata_o, 32'd0);
    @(negedge clk_i);
    reset_n = 1'b1;

    applyStimulus("divu 100/7", OP_DIVU, 32'd100, 32'd7, 5'd5, 33, 32, 32'd14, 5'd5, -1, -1);
    applyStimulus("remu 100/7", OP_REMU, 32'd100, 32'd7, 5'd6, 33, 32, 32'd2, 5'd6, -1, -1);
    applyStimulus("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 33, 32, 32'hFFFF_FFFD, 5'd1, -1, -1);
    applyStimulus("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 33, 32, 32'hFFFF_FFFF, 5'd2, -1, -1);
    applyStimulus("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3, 33, 32, 32'hFFFF_FFFD, 5'd3, -1, -1);
    applyStimulus("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 33, 32, 32'd1, 5'd4, -1, -1);
    applyStimulus("div 123/0", OP_DIV, 32'd123, 32'd0, 5'd3, 1, 0, 32'hFFFF_FFFF, 5'd3, -1, -1);
    applyStimulus("remu 123/0", OP_REMU, 32'd123, 32'd0, 5'd4, 1, 0, 32'd123, 5'd4, -1, -1);
    applyStimulus("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1, 0, 32'h8000_0000, 5'd7, -1, -1);
    applyStimulus("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1, 0, 32'd0, 5'd8, -1, -1);
    applyStimulus("rd0 divu 10/3", OP_DIVU, 32'd10, 32'd3, 5'd0, 33, -1, 32'd3, 5'd0, -1, -1);
    applyStimulus("busy start", OP_DIVU, 32'd100, 32'd7, 5'd8, 33, 32, 32'd14, 5'd8, 9, -1);
    applyStimulus("kill calc", OP_DIVU, 32'd1000, 32'd10, 5'd10, 15, -1, 32'd14, 5'd8, -1, 14);
    applyStimulus("kill done", OP_DIVU, 32'd1000, 32'd10, 5'd10, 33, -1, 32'd100, 5'd10, -1, 32);
    applyStimulus("start at done", OP_DIVU, 32'd50, 32'd5, 5'd11, 33, 32, 32'd10, 5'd11, 32, -1);
    applyStimulus("kill+start idle", OP_DIVU, 32'd20, 32'd4, 5'd14, 33, 32, 32'd5, 5'd14, -1, -2);

    resetMidCalc();
    applyStimulus("divu 9/3 after rst", OP_DIVU, 32'd9, 32'd3, 5'd7, 33, 32, 32'd3, 5'd7, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have no parameters; datapath fixed at 32 bits (RV32M), register address fixed at 5 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request strobe; sampled on rising edge only while idle.
REQ-005 op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with start_i.
REQ-006 rs1_i  input  32  dividend; captured with start_i.
REQ-007 rs2_i  input  32  divisor; captured with start_i.
REQ-008 rd_addr_i  input  5  destination register; captured with start_i.
REQ-009 kill_i  input  1  synchronous flush of the operation in flight.
REQ-010 busy_o  output  1  high whenever state is not IDLE.
REQ-011 RegWrite_o  output  1  one-cycle write strobe to the register-file write port.
REQ-012 RDaddr_o  output  5  destination address, valid while RegWrite_o high.
REQ-013 RDdata_o  output  32  result, valid while RegWrite_o high.

Function
REQ-014 SHALL implement three states: IDLE, CALC, DONE.
REQ-015 IDLE: start_i=1 at rising edge E0 captures op_i, rs1_i, rs2_i, rd_addr_i; next state CALC, or DONE directly if special case (REQ-019/020).
REQ-016 CALC: restoring radix-2 unsigned division on operand magnitudes, one quotient bit per cycle, exactly 32 cycles (E1..E32); next state DONE at E32.
REQ-017 DONE: lasts exactly one cycle; RegWrite_o=1, RDaddr_o, RDdata_o valid for that cycle; next state IDLE.
REQ-018 Latency: normal op RegWrite_o high between E32 and E33; special case high between E0 and E1.
REQ-019 Divide by zero (rs2=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1; no CALC cycles.
REQ-020 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000, REM result 0; no CALC cycles.
REQ-021 Signed ops: quotient negated when operand signs differ; remainder takes sign of dividend; two's-complement 32-bit wrap.
REQ-022 rd_addr_i=0: operation runs normally but RegWrite_o SHALL stay 0 in DONE (x0 protection, register file does not hardwire x0).
REQ-023 start_i while busy_o=1 SHALL be ignored; no queueing; captured operands unchanged.
REQ-024 start_i and kill_i both high in IDLE: start accepted; kill_i only acts on CALC/DONE.
REQ-025 kill_i=1 in CALC or DONE: RegWrite_o forced 0 that cycle, next state IDLE, no write ever issued for that op.
REQ-026 Start at the same edge as DONE->IDLE transition SHALL be ignored (state is DONE, not IDLE, at that edge).
REQ-027 RDaddr_o/RDdata_o hold last result after DONE until next DONE; only RegWrite_o qualifies them.
REQ-028 Outputs registered except RegWrite_o, which SHALL be (state==DONE) & ~kill_i & (rd!=0).

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, busy_o=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, internal operand/quotient/remainder registers 0, regardless of clock.
REQ-030 Reset mid-CALC or in DONE SHALL abandon the operation with no write; after release, first start_i edge is accepted normally.

Verification
REQ-031 DIVU rs1=100, rs2=7, rd=5 -> busy_o high 33 cycles; RegWrite_o one cycle between E32/E33; RDaddr_o=5, RDdata_o=14; REMU same operands -> 2.
REQ-032 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD, REM -> 1.
REQ-033 DIV 123/0 -> 0xFFFFFFFF with RegWrite_o between E0/E1; REMU 123/0 -> 123; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-034 rd=0 DIVU 10/3 -> busy_o 33 cycles, RegWrite_o never high; start_i pulsed at E10 of a busy op -> ignored, original result written at E32/E33.
REQ-035 kill_i=1 at CALC cycle 15 -> no RegWrite_o, busy_o low from next edge; kill_i in DONE cycle -> RegWrite_o low that cycle.
REQ-036 reset_n low mid-CALC (cycle 20) -> busy_o, RegWrite_o, RDaddr_o, RDdata_o 0 immediately without clock; new DIVU 9/3 after release -> 3.
